// File: rtl/debug_tx_serializer.sv
// Pops words from a first-word-fall-through FIFO and streams them as framed bytes:
// optional header, count data bytes in either order, optional XOR checksum.
module debug_tx_serializer #(
    parameter int         NUM_BYTES   = 4,
    parameter int         SIZE_W      = 2,
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter bit         CHK_EN      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_empty,
    input  logic [8*NUM_BYTES-1:0] result,
    input  logic [SIZE_W-1:0]      size,
    input  logic                   msb_first,
    input  logic                   wr_full,
    output logic                   rd,
    output logic                   wr,
    output logic [7:0]             w_data,
    output logic                   busy,
    output logic [1:0]             fsm_state
);

    // Handshake: a byte is transferred on every rising edge where wr=1; wr already
    // folds in wr_full, so the sink never sees a write while it reports full.

    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   load;
    logic                   rd_q;
    logic [8*NUM_BYTES-1:0] data_q;
    logic                   msb_q;
    logic [CNT_W-1:0]       count_q;
    logic [IDX_W-1:0]       idx_q;
    logic [7:0]             chk_q;
    logic [7:0]             cur_byte;
    logic                   last_byte;
    logic [SIZE_W:0]        size_p1;
    logic [CNT_W-1:0]       count_in;

    assign size_p1 = {1'b0, size} + {{SIZE_W{1'b0}}, 1'b1};

    // Oversized requests are clamped; the upper bytes of the word are dropped.
    always_comb begin
        if (int'(size_p1) > NUM_BYTES) count_in = CNT_W'(NUM_BYTES);
        else                           count_in = CNT_W'(size_p1);
    end

    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) cur_byte = data_q[8*i +: 8];
        end
    end

    assign last_byte = msb_q ? (idx_q == '0)
                             : (idx_q == IDX_W'(count_q - CNT_W'(1)));

    assign busy      = (state_q != IDLE);
    assign wr        = busy & ~wr_full;
    assign rd        = rd_q;
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rd_empty) begin
                    load    = 1'b1;
                    state_d = HEADER_EN ? HDR : DATA;
                end
            end
            HDR: begin
                if (wr) state_d = DATA;
            end
            DATA: begin
                if (wr && last_byte) state_d = CHK_EN ? CHK : IDLE;
            end
            CHK: begin
                if (wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_data = 8'h00;
        unique case (state_q)
            HDR:     w_data = HEADER_BYTE;
            DATA:    w_data = cur_byte;
            CHK:     w_data = chk_q;
            default: w_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= 1'b0;
            data_q  <= '0;
            msb_q   <= 1'b0;
            count_q <= '0;
            idx_q   <= '0;
            chk_q   <= 8'h00;
        end else begin
            rd_q <= load;
            if (load) begin
                data_q  <= result;
                msb_q   <= msb_first;
                count_q <= count_in;
                idx_q   <= msb_first ? IDX_W'(count_in - CNT_W'(1)) : '0;
                chk_q   <= 8'h00;
            end else if (state_q == DATA && wr) begin
                chk_q <= chk_q ^ cur_byte;
                if (!last_byte) idx_q <= msb_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_debug_tx_serializer.sv
// Bench for debug_tx_serializer: default instance plus a headerless, checksum-free
// 2-byte instance; directed words with hand-computed byte streams.
module tb_debug_tx_serializer;

    logic        clk = 1'b0;
    logic        reset;

    logic        rd_empty_a, msb_a, wr_full_a;
    logic [31:0] result_a;
    logic [1:0]  size_a;
    logic        rd_a, wr_a, busy_a;
    logic [7:0]  w_data_a;
    logic [1:0]  state_a;

    logic        rd_empty_b, msb_b, wr_full_b;
    logic [15:0] result_b;
    logic [1:0]  size_b;
    logic        rd_b, wr_b, busy_b;
    logic [7:0]  w_data_b;
    logic [1:0]  state_b;

    typedef struct {
        logic [31:0] r;
        logic [1:0]  s;
        logic        m;
    } word_t;

    word_t      src_q[$];
    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int sent_a = 0, rd_cnt_a = 0, frames_a = 0, last_len_a = 0, last_gap_a = 0;
    int rd_cnt_b = 0, frames_b = 0, last_len_b = 0;

    debug_tx_serializer u_a (
        .clk(clk), .reset(reset), .rd_empty(rd_empty_a), .result(result_a),
        .size(size_a), .msb_first(msb_a), .wr_full(wr_full_a), .rd(rd_a),
        .wr(wr_a), .w_data(w_data_a), .busy(busy_a), .fsm_state(state_a)
    );

    debug_tx_serializer #(
        .NUM_BYTES(2), .SIZE_W(2), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5), .CHK_EN(1'b0)
    ) u_b (
        .clk(clk), .reset(reset), .rd_empty(rd_empty_b), .result(result_b),
        .size(size_b), .msb_first(msb_b), .wr_full(wr_full_b), .rd(rd_b),
        .wr(wr_b), .w_data(w_data_b), .busy(busy_b), .fsm_state(state_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // source FIFO model for instance a: pops on the edge that ends an rd cycle
    initial begin
        logic pop;
        forever begin
            @(negedge clk);
            pop = rd_a;
            @(posedge clk);
            #2;
            if (pop && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                rd_empty_a = 1'b0;
                result_a   = src_q[0].r;
                size_a     = src_q[0].s;
                msb_a      = src_q[0].m;
            end else begin
                rd_empty_a = 1'b1;
            end
        end
    end

    // scoreboard monitor a
    initial begin
        logic prev_rd = 1'b0, prev_busy = 1'b0;
        int   cur_len = 0, idle_cnt = 0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (wr_a) begin
                sent_a++;
                if (exp_q_a.size() == 0) begin
                    total_cnt++;
                    $display("FAIL byte_a actual=%0h required=no_write", w_data_a);
                end else begin
                    e = exp_q_a.pop_front();
                    check("byte_a", {24'h0, w_data_a}, {24'h0, e});
                end
            end
            if (rd_a) begin
                rd_cnt_a++;
                check("rd_a_single_cycle", {31'h0, prev_rd}, 32'h0);
            end
            prev_rd = rd_a;
            if (busy_a) begin
                if (!prev_busy) begin
                    last_gap_a = idle_cnt;
                    cur_len = 0;
                end
                cur_len++;
            end else begin
                if (prev_busy) begin
                    last_len_a = cur_len;
                    frames_a++;
                    idle_cnt = 0;
                end
                idle_cnt++;
            end
            prev_busy = busy_a;
        end
    end

    // scoreboard monitor b
    initial begin
        logic prev_busy = 1'b0;
        int   cur_len = 0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (wr_b) begin
                if (exp_q_b.size() == 0) begin
                    total_cnt++;
                    $display("FAIL byte_b actual=%0h required=no_write", w_data_b);
                end else begin
                    e = exp_q_b.pop_front();
                    check("byte_b", {24'h0, w_data_b}, {24'h0, e});
                end
            end
            if (rd_b) rd_cnt_b++;
            if (busy_b) begin
                if (!prev_busy) cur_len = 0;
                cur_len++;
            end else if (prev_busy) begin
                last_len_b = cur_len;
                frames_b++;
            end
            prev_busy = busy_b;
        end
    end

    // driver tasks
    task automatic push_a(input logic [31:0] r, input logic [1:0] s, input logic m);
        word_t w;
        w.r = r; w.s = s; w.m = m;
        src_q.push_back(w);
    endtask

    task automatic wait_frames_a(input int target);
        int n = 0;
        while (frames_a < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("frame_done_a", frames_a, target);
    endtask

    task automatic end_frame_a(input string name, input int frames, input int len, input int rds);
        wait_frames_a(frames);
        check({name, "_len"}, last_len_a, len);
        check({name, "_rd_pulses"}, rd_cnt_a, rds);
        check({name, "_exp_empty"}, exp_q_a.size(), 0);
        check({name, "_busy_low"}, {31'h0, busy_a}, 32'h0);
    endtask

    task automatic send_b(input logic [15:0] r, input logic [1:0] s, input logic m, input int frames, input int len);
        int n = 0;
        result_b = r; size_b = s; msb_b = m; rd_empty_b = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_b && n < 20);
        check("rd_b_seen", {31'h0, rd_b}, 32'h1);
        @(posedge clk); #1;
        rd_empty_b = 1'b1;
        n = 0;
        while (frames_b < frames && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("frame_done_b", frames_b, frames);
        check("len_b", last_len_b, len);
        check("exp_empty_b", exp_q_b.size(), 0);
    endtask

    initial begin
        int base, n;
        reset = 1'b1;
        rd_empty_a = 1'b1; result_a = '0; size_a = '0; msb_a = 1'b0; wr_full_a = 1'b0;
        rd_empty_b = 1'b1; result_b = '0; size_b = '0; msb_b = 1'b0; wr_full_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_rd", {31'h0, rd_a}, 32'h0);
        check("reset_wr", {31'h0, wr_a}, 32'h0);
        check("reset_busy", {31'h0, busy_a}, 32'h0);
        check("reset_w_data", {24'h0, w_data_a}, 32'h0);
        check("reset_state", {30'h0, state_a}, 32'h0);
        @(posedge clk); #1;

        // full word, msb first
        exp_q_a = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        push_a(32'h11223344, 2'd3, 1'b1);
        end_frame_a("msb4", 1, 6, 1);

        // short words, lsb first
        exp_q_a = '{8'hA5, 8'h44, 8'h44};
        push_a(32'h11223344, 2'd0, 1'b0);
        end_frame_a("lsb1", 2, 3, 2);
        exp_q_a = '{8'hA5, 8'h44, 8'h33, 8'h77};
        push_a(32'h11223344, 2'd1, 1'b0);
        end_frame_a("lsb2", 3, 4, 3);

        // back-pressure for 3 cycles on the second byte
        exp_q_a = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        base = sent_a;
        push_a(32'h11223344, 2'd3, 1'b1);
        n = 0;
        while (sent_a - base < 1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        wr_full_a = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_wr", {31'h0, wr_a}, 32'h0);
            check("stall_w_data", {24'h0, w_data_a}, 32'h11);
            check("stall_state", {30'h0, state_a}, 32'h2);
            @(posedge clk); #1;
        end
        wr_full_a = 1'b0;
        end_frame_a("stall", 4, 9, 4);

        // two words queued back to back
        exp_q_a = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44,
                    8'hA5, 8'hDD, 8'hCC, 8'h11};
        push_a(32'h11223344, 2'd3, 1'b1);
        push_a(32'hAABBCCDD, 2'd1, 1'b0);
        end_frame_a("b2b", 6, 4, 6);
        check("b2b_gap", last_gap_a, 1);

        // reset in the middle of a frame, after two bytes have gone out
        exp_q_a = '{8'hA5, 8'h11, 8'h22};
        base = sent_a;
        push_a(32'h11223344, 2'd3, 1'b1);
        n = 0;
        while (sent_a - base < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_wr", {31'h0, wr_a}, 32'h0);
        check("abort_rd", {31'h0, rd_a}, 32'h0);
        check("abort_busy", {31'h0, busy_a}, 32'h0);
        check("abort_state", {30'h0, state_a}, 32'h0);
        check("abort_w_data", {24'h0, w_data_a}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_rd_pulses", rd_cnt_a, 7);
        check("abort_exp_empty", exp_q_a.size(), 0);
        exp_q_a = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        push_a(32'h11223344, 2'd3, 1'b1);
        end_frame_a("after_reset", 8, 6, 8);

        // clamped 2-byte instance without header or checksum
        exp_q_b = '{8'hBE, 8'hEF};
        send_b(16'hBEEF, 2'd3, 1'b1, 1, 2);
        exp_q_b = '{8'hEF};
        send_b(16'hBEEF, 2'd0, 1'b0, 2, 1);
        exp_q_b = '{8'hEF, 8'hBE};
        send_b(16'hBEEF, 2'd3, 1'b0, 3, 2);
        check("rd_pulses_b", rd_cnt_b, 3);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
